// File: rtl/control_fsm_if.sv
// rtl/control_fsm_if.sv - Datapath/controller signal bundle for the multicycle control FSM
//
// Groups every non-clock, non-reset signal between the control FSM and the
// datapath it steers.
//   slave  : the controller side (control_fsm). Consumes Instr/Zero/MemReady
//            and drives every control line plus Halt/Illegal/State.
//   master : the datapath side. Drives Instr/Zero/MemReady and observes the
//            control lines.
// Signal meanings:
//   Instr[23:0]  instruction register contents, [23:20] opcode, [3:0] funct
//   Zero         ALU zero flag
//   MemReady     memory completion strobe
//   ALUOp/Funct  ALU control inputs
//   ALUSrcB      00 reg B, 01 const 1, 10 sign-extended imm, 11 branch offset
//   PCSrc        00 ALU result, 01 ALUOut, 10 jump target
//   State        current controller state code

interface control_fsm_if;
    logic [23:0] Instr;
    logic        Zero;
    logic        MemReady;

    logic [1:0]  ALUOp;
    logic [3:0]  Funct;
    logic        MemReq;
    logic        MemWrite;
    logic        IorD;
    logic        IRWrite;
    logic        PCWrite;
    logic        RegWrite;
    logic        MemToReg;
    logic        RegDst;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  PCSrc;
    logic        Halt;
    logic        Illegal;
    logic [3:0]  State;

    modport master (
        output Instr, Zero, MemReady,
        input  ALUOp, Funct, MemReq, MemWrite, IorD, IRWrite, PCWrite,
               RegWrite, MemToReg, RegDst, ALUSrcA, ALUSrcB, PCSrc,
               Halt, Illegal, State
    );

    modport slave (
        input  Instr, Zero, MemReady,
        output ALUOp, Funct, MemReq, MemWrite, IorD, IRWrite, PCWrite,
               RegWrite, MemToReg, RegDst, ALUSrcA, ALUSrcB, PCSrc,
               Halt, Illegal, State
    );
endinterface

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - Multicycle processor control FSM
//
// Sequences fetch, decode, execute, memory access and write-back for a small
// multicycle datapath. All control outputs are a function of the current
// state, qualified only by MemReady (FETCH/MEM_READ/MEM_WRITE) and Zero
// (BRANCH).
// Ports:
//   Clock        rising-edge clock
//   Resetn       asynchronous active-low reset
//   bus (slave)  Instr/Zero/MemReady in; ALUOp, Funct, MemReq, MemWrite,
//                IorD, IRWrite, PCWrite, RegWrite, MemToReg, RegDst,
//                ALUSrcA, ALUSrcB, PCSrc, Halt, Illegal, State out
// Parameter:
//   MUL_CYCLES   cycles spent in EXEC_MUL holding ALUOp=11 (1..15)

module control_fsm #(
    parameter int unsigned MUL_CYCLES = 3
) (
    input  logic         Clock,
    input  logic         Resetn,
    control_fsm_if.slave bus
);

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_MUL  = 4'b0001;
    localparam logic [3:0] OP_LS   = 4'b0010;
    localparam logic [3:0] OP_SS   = 4'b0011;
    localparam logic [3:0] OP_BEQ  = 4'b0100;
    localparam logic [3:0] OP_BNE  = 4'b0101;
    localparam logic [3:0] OP_J    = 4'b0110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // Terminal count of the EXEC_MUL counter (counts 0 .. MUL_CYCLES-1).
    localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        EXEC_MUL  = 4'd3,
        WB_R      = 4'd4,
        MEM_ADDR  = 4'd5,
        MEM_READ  = 4'd6,
        MEM_WRITE = 4'd7,
        WB_MEM    = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        HALTED    = 4'd11
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [3:0] mul_cnt_q, mul_cnt_d;
    logic       illegal_q, illegal_d;

    logic [3:0] opcode;
    logic       mem_ready;

    logic [1:0] alu_op;
    logic [3:0] funct;
    logic       mem_req;
    logic       mem_write;
    logic       ior_d;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       halt;

    logic       unused_instr_bits;

    assign opcode            = bus.Instr[23:20];
    assign unused_instr_bits = ^bus.Instr[19:4];

    // While reset is held the outputs must look like FETCH with no memory
    // completion, so the strobe is masked rather than trusted.
    assign mem_ready = bus.MemReady & Resetn;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= FETCH;
            op_q      <= OP_R;
            mul_cnt_q <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            mul_cnt_q <= mul_cnt_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mul_cnt_d  = mul_cnt_q;
        illegal_d  = illegal_q;

        alu_op     = 2'b00;
        funct      = 4'b0000;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        ior_d      = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        halt       = 1'b0;

        unique case (state_q)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end

            DECODE: begin
                alu_src_b = 2'b11;
                // The opcode is captured here so later states keep the
                // chosen path even if Instr changes underneath them.
                op_d      = opcode;
                unique case (opcode)
                    OP_R:          state_d = EXEC_R;
                    OP_MUL: begin
                        state_d   = EXEC_MUL;
                        mul_cnt_d = 4'd0;
                    end
                    OP_LS, OP_SS:  state_d = MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = BRANCH;
                    OP_J:          state_d = JUMP;
                    OP_HALT:       state_d = HALTED;
                    default: begin
                        state_d   = HALTED;
                        illegal_d = 1'b1;
                    end
                endcase
            end

            EXEC_R: begin
                alu_op    = 2'b10;
                funct     = bus.Instr[3:0];
                alu_src_a = 1'b1;
                state_d   = WB_R;
            end

            EXEC_MUL: begin
                alu_op    = 2'b11;
                alu_src_a = 1'b1;
                if (mul_cnt_q == MUL_LAST) begin
                    state_d = WB_R;
                end else begin
                    mul_cnt_d = mul_cnt_q + 4'd1;
                end
            end

            WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = FETCH;
            end

            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op_q == OP_SS) ? MEM_WRITE : MEM_READ;
            end

            MEM_READ: begin
                mem_req = 1'b1;
                ior_d   = 1'b1;
                if (mem_ready) begin
                    state_d = WB_MEM;
                end
            end

            MEM_WRITE: begin
                mem_req   = 1'b1;
                ior_d     = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                end
            end

            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end

            BRANCH: begin
                alu_op    = 2'b01;
                alu_src_a = 1'b1;
                pc_src    = 2'b01;
                pc_write  = ((op_q == OP_BEQ) &&  bus.Zero) ||
                            ((op_q == OP_BNE) && !bus.Zero);
                state_d   = FETCH;
            end

            JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                state_d  = FETCH;
            end

            HALTED: begin
                halt = 1'b1;
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign bus.ALUOp    = alu_op;
    assign bus.Funct    = funct;
    assign bus.MemReq   = mem_req;
    assign bus.MemWrite = mem_write;
    assign bus.IorD     = ior_d;
    assign bus.IRWrite  = ir_write;
    assign bus.PCWrite  = pc_write;
    assign bus.RegWrite = reg_write;
    assign bus.MemToReg = mem_to_reg;
    assign bus.RegDst   = reg_dst;
    assign bus.ALUSrcA  = alu_src_a;
    assign bus.ALUSrcB  = alu_src_b;
    assign bus.PCSrc    = pc_src;
    assign bus.Halt     = halt;
    assign bus.Illegal  = illegal_q;
    assign bus.State    = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// tb/tb_control_fsm.sv - Self-checking bench for control_fsm

module tb_control_fsm;

    localparam int MULC = 3;

    logic Clock;
    logic Resetn;

    control_fsm_if bus ();

    control_fsm #(.MUL_CYCLES(MULC)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [3:0] op);
        return (op <= 4'd6) || (op == 4'hF);
    endfunction

    // Expected control outputs for a given state code, taken straight from
    // the per-state output table. Packed as
    // {ALUOp,Funct,MemReq,MemWrite,IorD,IRWrite,PCWrite,RegWrite,MemToReg,
    //  RegDst,ALUSrcA,ALUSrcB,PCSrc,Halt,Illegal}
    function automatic logic [20:0] exp_out(input int s, input logic [3:0] op,
                                            input logic [3:0] fn, input logic z,
                                            input logic mr);
        logic [1:0] aluop;
        logic [3:0] fu;
        logic memreq, memw, iord, irw, pcw, regw, m2r, rdst, srca, hlt, ill;
        logic [1:0] srcb, pcs;
        aluop = 0; fu = 0; memreq = 0; memw = 0; iord = 0; irw = 0; pcw = 0;
        regw = 0; m2r = 0; rdst = 0; srca = 0; srcb = 0; pcs = 0; hlt = 0; ill = 0;
        case (s)
            0: begin memreq = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            1: srcb = 2'b11;
            2: begin aluop = 2'b10; fu = fn; srca = 1; end
            3: begin aluop = 2'b11; srca = 1; end
            4: begin regw = 1; rdst = 1; end
            5: begin srca = 1; srcb = 2'b10; end
            6: begin memreq = 1; iord = 1; end
            7: begin memreq = 1; iord = 1; memw = 1; end
            8: begin regw = 1; m2r = 1; end
            9: begin
                aluop = 2'b01; srca = 1; pcs = 2'b01;
                pcw = ((op == 4'd4) && z) || ((op == 4'd5) && !z);
            end
            10: begin pcw = 1; pcs = 2'b10; end
            11: begin hlt = 1; ill = !is_legal(op); end
            default: ;
        endcase
        return {aluop, fu, memreq, memw, iord, irw, pcw, regw, m2r, rdst, srca,
                srcb, pcs, hlt, ill};
    endfunction

    function automatic logic [20:0] obs_out();
        return {bus.ALUOp, bus.Funct, bus.MemReq, bus.MemWrite, bus.IorD,
                bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemToReg,
                bus.RegDst, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc, bus.Halt,
                bus.Illegal};
    endfunction

    // Asynchronous reset in the middle of a clock phase: outputs must fall
    // to FETCH values at once, even with MemReady held high.
    task automatic async_reset(input string tag, input logic [3:0] op, input logic [3:0] fn);
        #2;
        Resetn = 1'b0;
        bus.MemReady = 1'b1;
        #1;
        check({tag, "_rst_state"}, 32'(bus.State), 32'd0);
        check({tag, "_rst_outs"}, 32'(obs_out()), 32'(exp_out(0, op, fn, bus.Zero, 1'b0)));
        @(negedge Clock);
        #2;
        bus.MemReady = 1'b0;
        Resetn = 1'b1;
        @(posedge Clock);
        #1;
    endtask

    // Runs one instruction starting in FETCH (called #1 after a rising edge).
    // The expected state trace is built from the instruction-level rules:
    // fetch waits, decode, then the opcode's path with its memory waits.
    // zmode < 0 drives random Zero; abort_at >= 0 cuts the trace and resets.
    task automatic run_instr(input string tag, input logic [3:0] op, input logic [3:0] fn,
                             input int fwait, input int mwait, input int zmode,
                             input int abort_at);
        int  q_s[$];
        bit  q_mr[$];
        int  n;
        int  mem_state;
        for (int i = 0; i < fwait; i++) begin q_s.push_back(0); q_mr.push_back(0); end
        q_s.push_back(0); q_mr.push_back(1);
        q_s.push_back(1); q_mr.push_back(1'($urandom));
        mem_state = -1;
        case (op)
            4'd0: begin q_s.push_back(2); q_s.push_back(4); end
            4'd1: begin
                for (int i = 0; i < MULC; i++) q_s.push_back(3);
                q_s.push_back(4);
            end
            4'd2: begin q_s.push_back(5); mem_state = 6; end
            4'd3: begin q_s.push_back(5); mem_state = 7; end
            4'd4, 4'd5: q_s.push_back(9);
            4'd6: q_s.push_back(10);
            default: for (int i = 0; i < 4; i++) q_s.push_back(11);
        endcase
        while (q_mr.size() < q_s.size()) q_mr.push_back(1'($urandom));
        if (mem_state >= 0) begin
            for (int i = 0; i < mwait; i++) begin q_s.push_back(mem_state); q_mr.push_back(0); end
            q_s.push_back(mem_state); q_mr.push_back(1);
            if (op == 4'd2) begin q_s.push_back(8); q_mr.push_back(1'($urandom)); end
        end

        n = (abort_at >= 0) ? abort_at : q_s.size();
        for (int idx = 0; idx < n; idx++) begin
            if (idx <= fwait + 1)
                bus.Instr = {op, 16'($urandom), fn};
            else
                bus.Instr = {4'($urandom), 16'($urandom), fn};
            bus.Zero     = (zmode < 0) ? 1'($urandom) : 1'(zmode);
            bus.MemReady = q_mr[idx];
            @(negedge Clock);
            check({tag, "_state"}, 32'(bus.State), 32'(q_s[idx]));
            check({tag, "_outs"}, 32'(obs_out()),
                  32'(exp_out(q_s[idx], op, fn, bus.Zero, bus.MemReady)));
            @(posedge Clock);
            #1;
        end

        if (abort_at >= 0 || !is_legal(op) || op == 4'hF) begin
            bus.MemReady = 1'b0;
            #1;
            n = (abort_at >= 0) ? abort_at : q_s.size() - 1;
            check({tag, "_pre_state"}, 32'(bus.State), 32'(q_s[n]));
            check({tag, "_pre_outs"}, 32'(obs_out()),
                  32'(exp_out(q_s[n], op, fn, bus.Zero, 1'b0)));
            async_reset(tag, op, fn);
        end
    endtask

    initial begin
        logic [3:0] op;
        int         pick;

        Resetn       = 1'b0;
        bus.Instr    = 24'h0;
        bus.Zero     = 1'b0;
        bus.MemReady = 1'b1;
        #2;
        check("reset_state", 32'(bus.State), 32'd0);
        check("reset_outs", 32'(obs_out()), 32'(exp_out(0, 4'd0, 4'd0, 1'b0, 1'b0)));
        @(negedge Clock);
        #2;
        bus.MemReady = 1'b0;
        Resetn = 1'b1;
        @(posedge Clock);
        #1;
        check("idle_fetch", 32'(bus.State), 32'd0);

        run_instr("r_fmt",   4'd0, 4'd2, 0, 0, -1, -1);
        run_instr("ls_wait", 4'd2, 4'd5, 0, 3, -1, -1);
        run_instr("beq_z1",  4'd4, 4'd0, 0, 0,  1, -1);
        run_instr("bne_z1",  4'd5, 4'd0, 0, 0,  1, -1);
        run_instr("bne_z0",  4'd5, 4'd0, 1, 0,  0, -1);
        run_instr("mul",     4'd1, 4'd0, 0, 0, -1, -1);
        run_instr("jump",    4'd6, 4'd0, 2, 0, -1, -1);
        run_instr("ss",      4'd3, 4'd0, 0, 1, -1, -1);
        run_instr("illegal", 4'd7, 4'd0, 0, 0, -1, -1);
        run_instr("halt",    4'hF, 4'd0, 1, 0, -1, -1);
        run_instr("ss_abort",  4'd3, 4'd0, 0, 3, -1, 4);
        run_instr("mul_abort", 4'd1, 4'd0, 0, 0, -1, 3);
        run_instr("r_after",   4'd0, 4'd9, 0, 0, -1, -1);

        for (int k = 0; k < 40; k++) begin
            pick = int'($urandom_range(0, 15));
            if (pick < 14) op = 4'(pick % 7);
            else if (pick == 14) op = 4'($urandom_range(7, 14));
            else op = 4'hF;
            run_instr("rand", op, 4'($urandom), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
